// File: rtl/register_file_pkg.sv
// Shared register-file constants and types for the core datapath.
// Zero-latency reads, one-edge writes, no backpressure (always ready).
package register_file_pkg;

    localparam int REG_DATA_W = 32;
    localparam int REG_ADDR_W = 5;
    localparam int REG_COUNT  = 32;
    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [REG_DATA_W-1:0] reg_data_t;

endpackage

// File: rtl/register_file_rf_read_port.sv
// Combinational read mux for one register-file port; address zero reads zero.
// Zero latency, no backpressure.
module rf_read_port
    import register_file_pkg::*;
#(
    parameter int DATA_W = REG_DATA_W,
    parameter int ADDR_W = REG_ADDR_W
) (
    input  logic [DATA_W-1:0] i_regs [2**ADDR_W],
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] o_dat
);

    assign o_dat = (i_addr == ADDR_W'(REG_ZERO)) ? '0 : i_regs[i_addr];

endmodule

// File: rtl/register_file.sv
// 32x32 register file: two combinational read ports, one clocked write port, x0 hardwired to 0.
// Reads zero latency, writes land on the rising edge; never stalls, no internal bypass.
module register_file
    import register_file_pkg::*;
#(
    parameter int DATA_W = REG_DATA_W,
    parameter int ADDR_W = REG_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] A1,
    input  logic [ADDR_W-1:0] A2,
    input  logic [ADDR_W-1:0] A3,
    input  logic [DATA_W-1:0] WD3,
    input  logic              WE,
    output logic [DATA_W-1:0] RD1,
    output logic [DATA_W-1:0] RD2
);

    localparam int DEPTH = 2**ADDR_W;

    logic [DATA_W-1:0] w_regs [DEPTH];

    // Entry 0 has no storage at all, so a write to it is dropped by construction.
    assign w_regs[0] = '0;

    for (genvar g = 1; g < DEPTH; g++) begin : g_reg
        logic [DATA_W-1:0] r_q;

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                r_q <= '0;
            end else if (WE && (A3 == ADDR_W'(g))) begin
                r_q <= WD3;
            end
        end

        assign w_regs[g] = r_q;
    end

    rf_read_port #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_rd1 (
        .i_regs (w_regs),
        .i_addr (A1),
        .o_dat  (RD1)
    );

    rf_read_port #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_rd2 (
        .i_regs (w_regs),
        .i_addr (A2),
        .o_dat  (RD2)
    );

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: directed cases plus random traffic vs. an array model.
module tb_register_file;

    logic        clk;
    logic        reset;
    logic [4:0]  A1, A2, A3;
    logic [31:0] WD3;
    logic        WE;
    logic [31:0] RD1, RD2;

    int n_checks;
    int n_errors;

    // Reference model: plain array of register contents, index 0 never written.
    logic [31:0] model [32];

    register_file dut (
        .clk   (clk),
        .reset (reset),
        .A1    (A1),
        .A2    (A2),
        .A3    (A3),
        .WD3   (WD3),
        .WE    (WE),
        .RD1   (RD1),
        .RD2   (RD2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model_rd(input logic [4:0] a);
        return (a == 5'd0) ? 32'd0 : model[a];
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 32; i++) model[i] = 32'd0;
    endtask

    // One rising edge; model applies the write the DUT should see at that edge.
    task automatic tick();
        logic        do_wr;
        logic [4:0]  wa;
        logic [31:0] wd;
        do_wr = reset && WE && (A3 != 5'd0);
        wa = A3;
        wd = WD3;
        @(posedge clk);
        if (do_wr) model[wa] = wd;
        #1;
    endtask

    task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
        WE = 1'b1; A3 = a; WD3 = d;
        tick();
        WE = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        model_clear();

        // Reset held with a live write request.
        reset = 1'b0; A1 = 5'd7; A2 = 5'd31; A3 = 5'd6; WD3 = 32'd2; WE = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("reset_rd1", RD1, 32'd0);
            check_eq("reset_rd2", RD2, 32'd0);
        end
        WE = 1'b0;
        reset = 1'b1;
        A1 = 5'd6;
        #1;
        check_eq("reset_write_ignored", RD1, 32'd0);

        // Write then read.
        write_reg(5'd6, 32'd2);
        A1 = 5'd6; A2 = 5'd31;
        #1;
        check_eq("wr_rd1", RD1, 32'd2);
        check_eq("wr_rd2", RD2, 32'd0);

        // Asynchronous reset between edges clears without a clock.
        #2;
        reset = 1'b0;
        #1;
        model_clear();
        check_eq("async_reset_rd1", RD1, 32'd0);
        reset = 1'b1;
        tick();

        // Zero register ignores writes.
        write_reg(5'd0, 32'hDEADBEEF);
        A1 = 5'd0;
        #1;
        check_eq("zero_reg", RD1, 32'd0);

        // Fill all registers, sweep both ports.
        for (int i = 1; i < 32; i++) write_reg(5'(i), 32'(i * 3 + 1));
        for (int i = 0; i < 32; i++) begin
            A1 = 5'(i); A2 = 5'(31 - i);
            #1;
            check_eq("sweep_rd1", RD1, (i == 0) ? 32'd0 : 32'(i * 3 + 1));
            check_eq("sweep_rd2", RD2, (31 - i == 0) ? 32'd0 : 32'((31 - i) * 3 + 1));
        end

        // Both ports on one address.
        write_reg(5'd8, 32'd2);
        A1 = 5'd8; A2 = 5'd8;
        #1;
        check_eq("same_addr_rd1", RD1, 32'd2);
        check_eq("same_addr_rd2", RD2, 32'd2);

        // Same-cycle read/write: old value until the edge, new after.
        WE = 1'b1; A3 = 5'd8; WD3 = 32'd5; A1 = 5'd8;
        #1;
        check_eq("rw_before_edge", RD1, 32'd2);
        tick();
        check_eq("rw_after_edge", RD1, 32'd5);
        WE = 1'b0;
        tick();
        check_eq("rw_hold", RD1, 32'd5);

        // Reset asserted in the cycle of a write wins.
        WE = 1'b1; A3 = 5'd9; WD3 = 32'h1234_5678; A1 = 5'd9;
        #2;
        reset = 1'b0;
        model_clear();
        tick();
        check_eq("reset_mid_write", RD1, 32'd0);
        WE = 1'b0;
        reset = 1'b1;
        tick();

        // Random traffic against the model.
        for (int n = 0; n < 400; n++) begin
            A1  = 5'($urandom_range(0, 31));
            A2  = 5'($urandom_range(0, 31));
            A3  = 5'($urandom_range(0, 31));
            WD3 = $urandom;
            WE  = ($urandom_range(0, 3) != 0);
            #1;
            check_eq("rand_rd1", RD1, model_rd(A1));
            check_eq("rand_rd2", RD2, model_rd(A2));
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
